// File: rtl/pipeline_hzctl.sv
// Hazard/stall controller for the five-stage pipeline: derives per-latch enable
// and bubble strobes, sequences the HALT drain, and keeps stall/flush counters.
module pipeline_hzctl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_dmemREN,
  input  logic [4:0]       idex_rt,
  input  logic             idex_halt,
  input  logic             exmem_dmemREN,
  input  logic             exmem_dmemWEN,
  input  logic             exmem_pcsrc,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_busy;
  logic lu_hz;
  logic redirect;

  assign mem_busy = (exmem_dmemREN | exmem_dmemWEN) & ~dhit;
  assign lu_hz    = idex_dmemREN & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Strobes are forced low while nRST is asserted so the latches hold during reset.
  always_comb begin
    state_d     = state_q;
    redirect    = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    if (nRST) begin
      unique case (state_q)
        RUN: begin
          if (mem_busy) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
          end else if (exmem_pcsrc) begin
            redirect    = 1'b1;
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (lu_hz) begin
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end else if (!ihit) begin
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end

          // A redirect squashes the HALT; a busy MEM stage defers the decision.
          if (idex_halt && !mem_busy && !exmem_pcsrc) begin
            state_d = DRAIN;
          end
        end

        DRAIN: begin
          if (mem_busy) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
          end else begin
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end
          if (memwb_halt) begin
            state_d = HALT;
          end
        end

        HALT: begin
          state_d = HALT;
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    halt_d      = halt_q | (state_q == HALT);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALT) begin
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (redirect && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hzctl.sv
// Randomized + directed bench for pipeline_hzctl against a "freeze depth" model
// of the pipeline (how many leading elements hold, where the bubble lands).
module tb_pipeline_hzctl;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             CLK;
  logic             nRST;
  logic             ihit, dhit;
  logic [4:0]       ifid_rs, ifid_rt, idex_rt;
  logic             ifid_uses_rt, idex_dmemREN, idex_halt;
  logic             exmem_dmemREN, exmem_dmemWEN, exmem_pcsrc, memwb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hzctl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dmemREN(idex_dmemREN), .idex_rt(idex_rt), .idex_halt(idex_halt),
    .exmem_dmemREN(exmem_dmemREN), .exmem_dmemWEN(exmem_dmemWEN),
    .exmem_pcsrc(exmem_pcsrc), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model state: 0 = running, 1 = draining, 2 = halted.
  int m_mode  = 0;
  bit m_halt  = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit busy_now();
    return (exmem_dmemREN || exmem_dmemWEN) && !dhit;
  endfunction

  // Element index: 0=pc 1=ifid 2=idex 3=exmem 4=memwb. A stall freezes
  // elements [0, depth) and injects a bubble into element 'depth'.
  function automatic void model_out(output logic [4:0] en, output logic [4:0] fl, output bit rd);
    int  depth;
    bit  luh;
    en = '0;
    fl = '0;
    rd = 0;
    if (!nRST || m_mode == 2) return;
    luh = idex_dmemREN && (idex_rt != 0) &&
          ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    depth = 0;
    if (busy_now())            depth = 4;
    else if (m_mode == 1)      depth = 1;
    else if (exmem_pcsrc)      rd = 1;
    else if (luh)              depth = 2;
    else if (!ihit)            depth = 1;
    for (int i = 0; i < 5; i++) en[i] = (i >= depth);
    if (depth > 0) fl[depth] = 1'b1;
    if (rd) fl[3:1] = 3'b111;
  endfunction

  task automatic step();
    logic [4:0] ee, ef;
    bit rd;
    @(negedge CLK);
    if (!nRST) begin
      m_mode = 0; m_halt = 0; m_stall = 0; m_flush = 0;
    end
    model_out(ee, ef, rd);
    check_val("en",    {27'd0, memwb_en, exmem_en, idex_en, ifid_en, pc_en}, {27'd0, ee});
    check_val("flush", {27'd0, memwb_flush, exmem_flush, idex_flush, ifid_flush, 1'b0}, {27'd0, ef});
    check_val("halt",  {31'd0, halt}, {31'd0, m_halt});
    check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check_val("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (nRST) begin
      if (m_mode == 2) begin
        m_halt = 1;
      end else begin
        if (!ee[0] && m_stall < SAT) m_stall++;
        if (rd && m_flush < SAT) m_flush++;
        if (m_mode == 0 && idex_halt && !busy_now() && !exmem_pcsrc) m_mode = 1;
        else if (m_mode == 1 && memwb_halt) m_mode = 2;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1; dhit = 1; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
    idex_dmemREN = 0; idex_rt = 0; idex_halt = 0;
    exmem_dmemREN = 0; exmem_dmemWEN = 0; exmem_pcsrc = 0; memwb_halt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    step();
    step();
    nRST = 1;
  endtask

  task automatic random_inputs();
    ihit          = ($urandom_range(0, 3) != 0);
    dhit          = ($urandom_range(0, 2) != 0);
    ifid_rs       = 5'($urandom_range(0, 3));
    ifid_rt       = 5'($urandom_range(0, 3));
    ifid_uses_rt  = 1'($urandom_range(0, 1));
    idex_dmemREN  = ($urandom_range(0, 2) == 0);
    idex_rt       = 5'($urandom_range(0, 3));
    idex_halt     = ($urandom_range(0, 14) == 0);
    exmem_dmemREN = ($urandom_range(0, 3) == 0);
    exmem_dmemWEN = ($urandom_range(0, 5) == 0);
    exmem_pcsrc   = ($urandom_range(0, 5) == 0);
    memwb_halt    = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    idle_inputs();
    nRST = 1;
    #1 nRST = 0;

    // Reset then idle running.
    do_reset();
    repeat (3) step();
    check_val("idle_stall_cnt", 32'(stall_cnt), 32'd0);
    $display("reset/idle: stall_cnt=%0d", stall_cnt);

    // Load-use stall and its two non-hazard variants.
    do_reset();
    idex_dmemREN = 1; idex_rt = 5; ifid_rs = 5;
    step();
    check_val("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    idex_rt = 0;
    step();
    idex_rt = 5; ifid_rs = 0; ifid_rt = 5; ifid_uses_rt = 0;
    step();
    check_val("lu_no_stall", 32'(stall_cnt), 32'd1);
    idle_inputs();
    $display("load-use: stall_cnt=%0d", stall_cnt);

    // Data miss overrides load-use and redirect; redirect taken when it completes.
    do_reset();
    exmem_dmemREN = 1; dhit = 0; exmem_pcsrc = 1;
    idex_dmemREN = 1; idex_rt = 3; ifid_rs = 3;
    repeat (3) step();
    check_val("miss_stall_cnt", 32'(stall_cnt), 32'd3);
    check_val("miss_flush_cnt", 32'(flush_cnt), 32'd0);
    dhit = 1;
    step();
    check_val("miss_redirect", 32'(flush_cnt), 32'd1);
    idle_inputs();
    $display("dcache miss: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);

    // Redirect squashes a HALT in EX.
    do_reset();
    exmem_pcsrc = 1; idex_halt = 1;
    step();
    idle_inputs();
    repeat (3) step();
    check_val("branch_halt_pc_en", {31'd0, pc_en}, 32'd1);
    check_val("branch_halt_halt", {31'd0, halt}, 32'd0);
    $display("branch vs halt: halt=%0d", halt);

    // Halt drain.
    do_reset();
    idex_halt = 1;
    step();
    idex_halt = 0;
    step();
    memwb_halt = 1;
    step();
    memwb_halt = 0;
    step();
    repeat (10) begin
      step();
      check_val("halt_held", {31'd0, halt}, 32'd1);
    end
    do_reset();
    check_val("halt_cleared", {31'd0, halt}, 32'd0);
    $display("halt drain: released by reset");

    // Counter saturation.
    do_reset();
    ihit = 0;
    repeat (20) step();
    check_val("stall_sat", 32'(stall_cnt), 32'd15);
    idle_inputs();
    $display("saturation: stall_cnt=%0d", stall_cnt);

    // Randomized episodes, with occasional mid-run resets.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        random_inputs();
        if ($urandom_range(0, 99) == 0) nRST = 0;
        else nRST = 1;
        step();
      end
      nRST = 1;
      $display("episode %0d: mode=%0d stall_cnt=%0d flush_cnt=%0d", ep, m_mode, stall_cnt, flush_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hzctl.md
Name: pipeline_hzctl

Overview:
- Control-side counterpart of the inter-stage pipeline latches. Consumes hazard-relevant fields from the IF/ID, ID/EX and EX/MEM latches and the cache hit lines.
- Produces the per-latch enable and flush strobes that the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC consume.
- Also owns the halt drain sequence and the stall/flush performance counters.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters

Ports:
CLK  in  1  clock; all state updates on the rising edge
nRST  in  1  asynchronous reset, active-low
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
ifid_rs  in  5  rs field of the instruction in ID
ifid_rt  in  5  rt field of the instruction in ID
ifid_uses_rt  in  1  instruction in ID reads rt
idex_dmemREN  in  1  instruction in EX is a load
idex_rt  in  5  destination of the load in EX
idex_halt  in  1  instruction in EX is HALT
exmem_dmemREN  in  1  load in MEM
exmem_dmemWEN  in  1  store in MEM
exmem_pcsrc  in  1  taken branch/jump resolved in MEM
memwb_halt  in  1  HALT in WB
pc_en  out  1  PC update enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (all fields zero) into latch; a flush is only meaningful with the matching en=1
halt  out  1  sticky CPU halted
stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN or DRAIN
flush_cnt  out  CNT_W  number of branch redirects

Behaviour:
- Reset: asynchronous, active-low.
  - While nRST=0, all en and flush outputs are 0.
  - State=RUN, halt=0, counters=0.
- Derived terms:
  - mem_busy = (exmem_dmemREN | exmem_dmemWEN) & ~dhit.
  - lu_hz = idex_dmemREN & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- FSM states: RUN, DRAIN, HALT. Registered; outputs are combinational from state and inputs.
- RUN priority, highest first:
  1. mem_busy: pc_en=ifid_en=idex_en=exmem_en=0; memwb_en=1, memwb_flush=1.
  2. exmem_pcsrc: all en=1; ifid_flush=idex_flush=exmem_flush=1. flush_cnt+1.
  3. lu_hz: pc_en=ifid_en=0; idex_en=1, idex_flush=1; exmem_en=memwb_en=1.
  4. ~ihit: pc_en=0; ifid_en=1, ifid_flush=1; remaining en=1.
  5. Otherwise: all en=1, all flush=0.
- RUN -> DRAIN when idex_halt=1, mem_busy=0 and exmem_pcsrc=0. A redirect squashes the HALT, so the FSM stays in RUN. If mem_busy, the HALT is held and the transition is re-evaluated next cycle.
- DRAIN:
  - pc_en=0; ifid_en=1, ifid_flush=1; idex/exmem/memwb en=1.
  - Rule 1 (mem_busy) still overrides. lu_hz and ~ihit are ignored.
  - exmem_pcsrc cannot occur: the branch is older than the HALT.
  - DRAIN -> HALT when memwb_halt=1.
- HALT: all en=0, all flush=0. halt=1 is registered: it goes high on the cycle after entering HALT and stays high until nRST. No exit except reset.
- Counters:
  - stall_cnt increments on each cycle in RUN or DRAIN with pc_en=0.
  - flush_cnt increments on each rule-2 cycle.
  - Both saturate at all-ones (no wrap) and freeze in HALT.
- Reset mid-stall or mid-drain returns to RUN immediately; no pending state survives.

Test Plan:
- Reset/idle: nRST=0 for 2 cycles, then ihit=1 with no hazards -> during reset all en=0; after release all en=1, flushes 0, stall_cnt=0.
- Load-use:
  - Stimulus: idex_dmemREN=1, idex_rt=5, ifid_rs=5 for 1 cycle.
  - Response: pc_en=0, ifid_en=0, idex_flush=1, stall_cnt=1.
  - Repeat with idex_rt=0 -> no stall.
  - Repeat with ifid_rt=5 and ifid_uses_rt=0 -> no stall.
- dcache miss: exmem_dmemREN=1, dhit=0 for 3 cycles, with lu_hz and exmem_pcsrc also asserted -> front four en=0, memwb_flush=1 each cycle, stall_cnt=3. On the dhit=1 cycle the redirect is taken and flush_cnt=1.
- Branch vs HALT: exmem_pcsrc=1 and idex_halt=1 in the same cycle -> three flushes asserted, state stays RUN, halt stays 0.
- Halt drain:
  - Stimulus: idex_halt=1 in RUN, memwb_halt=1 two cycles later.
  - Response: pc_en=0 with ifid_flush=1 during DRAIN; next cycle all en=0; halt=1 one cycle later, held through 10 further cycles until nRST=0.
- Saturation: with CNT_W=4, hold ihit=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
